shower_session_ctrl: RTL and testbench
======================================

SHOWER_SESSION_CTRL -- requirements
Module: shower_session_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000: clock frequency used to derive the 1 s tick.
REQ-002 SHALL have parameter N_CARDS, default 4: number of authorised card IDs.
REQ-003 SHALL have parameter CARD_IDS, default {8'hFE,8'h86,8'h40,8'h2B}: packed N_CARDS x 8-bit ID list, entry 0 in LSBs.
REQ-004 SHALL have parameter DEF_TIME, default 12'h300: BCD m:ss session time used when no time is programmed.
REQ-005 SHALL have parameter MAX_MIN, default 5: largest accepted minutes digit.
REQ-006 SHALL have parameter VOL_LIMIT, default 20000: per-session consumption cap in ml.
REQ-007 SHALL have parameter PAUSE_TO_S, default 60: maximum PAUSE dwell in seconds.
REQ-008 SHALL have parameter MSG_S, default 2: seconds each rotating message is shown.
REQ-009 SHALL have ports: Clk in 1, system clock; Rst_n in 1, reset (one clock; reset is asynchronous and active-low).
REQ-010 SHALL have ports: key_valid in 1, one-cycle pulse per keypress; key_code in 4, key value (0-9 digits, A-D letters, E='#', F='*').
REQ-011 SHALL have ports: card_valid in 1, one-cycle pulse per card read; card_id in 8, card ID read.
REQ-012 SHALL have ports: occupied in 1, 1 = person present; time_left in 12, BCD remaining time from timer; timer_zero in 1, timer expired; volume_ml in 16, free-running cumulative flow count.
REQ-013 SHALL have ports: timer_load out 1, one-cycle load strobe; timer_value out 12, BCD load value; timer_run out 1, timer enable; valve_open out 1, valve command.
REQ-014 SHALL have ports: msg_id out 4, LCD message select; disp_value out 16, 7-segment value; session_done out 1, one-cycle pulse on DONE entry; state out 3, current state code.

Function
REQ-015 SHALL implement states IDLE=0, MENU=1, SET_MIN=2, SET_DEC=3, SET_SEG=4, RUN=5, PAUSE=6, DONE=7; any illegal code goes to IDLE next cycle.
REQ-016 SHALL act on keys only in cycles with key_valid=1; a held key generates no repeated action.
REQ-017 SHALL transition: IDLE -A-> MENU; MENU -B-> RUN (DEF_TIME); MENU -C-> SET_MIN (entry buffer cleared to 12'h000).
REQ-018 SHALL accept digits <=MAX_MIN in SET_MIN into bits [11:8], <=5 in SET_DEC into [7:4], <=9 in SET_SEG into [3:0]; other keys except '*' are ignored; the last accepted digit wins.
REQ-019 SHALL advance on '*': SET_MIN->SET_DEC->SET_SEG->RUN; on leaving SET_SEG a buffer of 12'h000 loads DEF_TIME instead.
REQ-020 SHALL pulse timer_load for exactly one cycle on the RUN entry cycle from MENU or SET_SEG, with timer_value equal to the loaded value; no load occurs on resume from PAUSE.
REQ-021 SHALL latch volume baseline = volume_ml on the same cycle as timer_load; consumption = volume_ml - baseline, modulo 2^16.
REQ-022 SHALL in RUN assert timer_run=1 and valve_open=1; in all other states both are 0.
REQ-023 SHALL resolve RUN exits with priority: authorised card -> DONE; consumption >= VOL_LIMIT -> DONE; timer_zero -> DONE; key D or occupied=0 -> PAUSE.
REQ-024 SHALL treat a card as authorised when card_valid=1 and card_id matches any CARD_IDS entry; unauthorised cards are ignored.
REQ-025 SHALL in PAUSE: authorised card -> DONE; else PAUSE_TO_S ticks elapsed -> DONE; else key A with occupied=1 -> RUN; the pause counter clears on PAUSE entry.
REQ-026 SHALL in DONE pulse session_done once on entry and freeze consumption; key E -> IDLE.
REQ-027 SHALL drive disp_value: IDLE/MENU 0; SET_* {4'h0, entry buffer}; RUN/PAUSE {4'h0, time_left}; DONE frozen consumption.
REQ-028 SHALL rotate msg_id every MSG_S seconds through the state's list, restarting at the first entry on every state change: IDLE 0,1; MENU 3,4; SET_MIN 5,14; SET_DEC 6,14; SET_SEG 7,14; RUN 8,9,10; PAUSE 1,10; DONE 11,13,12.
REQ-029 SHALL derive a 1 s tick from a CLK_HZ-cycle counter that free-runs, with the message and pause counters counting ticks.

Reset
REQ-030 SHALL on Rst_n=0 asynchronously force state=IDLE, all strobes 0, timer_run=0, valve_open=0, msg_id=0, disp_value=0, timer_value=0, and clear all counters, buffers and baseline; reset mid-RUN closes the valve immediately.

Verification
REQ-031 SHALL cover: A, B presses -> RUN, one timer_load with timer_value=12'h300, valve_open=1.
REQ-032 SHALL cover: A, C, 7 (rejected), 4, *, 6 (rejected), 3, *, 9, * -> timer_value=12'h439.
REQ-033 SHALL cover: RUN with volume_ml rising from baseline 1000 to 21000 -> DONE, session_done pulse, disp_value=20000.
REQ-034 SHALL cover: RUN, occupied=0 -> PAUSE, valve_open=0; A with occupied=1 -> RUN with no timer_load; PAUSE held 60 ticks -> DONE.
REQ-035 SHALL cover: card 8'h11 in RUN -> no effect; card 8'h86 coincident with timer_zero -> DONE, single session_done.
REQ-036 SHALL cover: Rst_n low mid-RUN -> state=0 and valve_open=0 with no clock edge required.

Source files
------------

// File: rtl/shower_session_ctrl.sv
// Shower session controller: card/keypad driven session FSM that programs an
// external BCD countdown timer, drives the water valve, caps per-session
// consumption and selects rotating LCD messages / 7-segment content.
`timescale 1ns/1ps
module shower_session_ctrl #(
    parameter int                     CLK_HZ     = 50_000_000,
    parameter int                     N_CARDS    = 4,
    parameter logic [N_CARDS*8-1:0]   CARD_IDS   = {8'hFE, 8'h86, 8'h40, 8'h2B},
    parameter logic [11:0]            DEF_TIME   = 12'h300,
    parameter int                     MAX_MIN    = 5,
    parameter int                     VOL_LIMIT  = 20000,
    parameter int                     PAUSE_TO_S = 60,
    parameter int                     MSG_S      = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        card_valid,
    input  logic [7:0]  card_id,
    input  logic        occupied,
    input  logic [11:0] time_left,
    input  logic        timer_zero,
    input  logic [15:0] volume_ml,
    output logic        timer_load,
    output logic [11:0] timer_value,
    output logic        timer_run,
    output logic        valve_open,
    output logic [3:0]  msg_id,
    output logic [15:0] disp_value,
    output logic        session_done,
    output logic [2:0]  state
);
    localparam logic [2:0] S_IDLE = 3'd0, S_MENU = 3'd1, S_SET_MIN = 3'd2, S_SET_DEC = 3'd3,
                           S_SET_SEG = 3'd4, S_RUN = 3'd5, S_PAUSE = 3'd6, S_DONE = 3'd7;
    localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int PW = $clog2(PAUSE_TO_S + 2);
    localparam int MW = $clog2(MSG_S + 1);

    logic [2:0]    state_nx;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [PW-1:0] pause_cnt;
    logic [MW-1:0] msg_sec;
    logic [1:0]    msg_idx;
    logic [11:0]   ebuf;
    logic [11:0]   load_val;
    logic [15:0]   baseline, frozen, cons;
    logic          card_ok, key_digit, do_load;

    assign tick      = (tick_cnt == TW'(CLK_HZ - 1));
    assign cons      = volume_ml - baseline;
    assign key_digit = key_valid && (key_code <= 4'd9);
    assign do_load   = (state_nx == S_RUN) && ((state == S_MENU) || (state == S_SET_SEG));
    // An empty programmed entry falls back to the default session time
    assign load_val  = (state == S_SET_SEG && ebuf != 12'h000) ? ebuf : DEF_TIME;

    // Card authorisation: match against any entry of the ID list
    always_comb begin
        card_ok = 1'b0;
        for (int i = 0; i < N_CARDS; i++)
            if (card_valid && card_id == CARD_IDS[i*8 +: 8]) card_ok = 1'b1;
    end

    // Free-running 1 s tick prescaler
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; RUN/PAUSE exits follow card > volume > timer > pause priority
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (key_valid && key_code == 4'hA) state_nx = S_MENU;
            S_MENU:    if (key_valid && key_code == 4'hB) state_nx = S_RUN;
                       else if (key_valid && key_code == 4'hC) state_nx = S_SET_MIN;
            S_SET_MIN: if (key_valid && key_code == 4'hF) state_nx = S_SET_DEC;
            S_SET_DEC: if (key_valid && key_code == 4'hF) state_nx = S_SET_SEG;
            S_SET_SEG: if (key_valid && key_code == 4'hF) state_nx = S_RUN;
            S_RUN:     if (card_ok)                          state_nx = S_DONE;
                       else if (cons >= 16'(VOL_LIMIT))      state_nx = S_DONE;
                       else if (timer_zero)                  state_nx = S_DONE;
                       else if ((key_valid && key_code == 4'hD) || !occupied) state_nx = S_PAUSE;
            S_PAUSE:   if (card_ok)                          state_nx = S_DONE;
                       else if (pause_cnt >= PW'(PAUSE_TO_S)) state_nx = S_DONE;
                       else if (key_valid && key_code == 4'hA && occupied) state_nx = S_RUN;
            S_DONE:    if (key_valid && key_code == 4'hE) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Entry buffer: cleared on entering programming, one BCD digit per SET state
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) ebuf <= 12'h000;
        else if (state == S_MENU && key_valid && key_code == 4'hC) ebuf <= 12'h000;
        else if (state == S_SET_MIN && key_digit && key_code <= 4'(MAX_MIN)) ebuf[11:8] <= key_code;
        else if (state == S_SET_DEC && key_digit && key_code <= 4'd5) ebuf[7:4] <= key_code;
        else if (state == S_SET_SEG && key_digit) ebuf[3:0] <= key_code;
    end

    // Timer load strobe, volume baseline, DONE pulse and frozen consumption
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            timer_load   <= 1'b0;
            timer_value  <= 12'h000;
            baseline     <= 16'h0;
            session_done <= 1'b0;
            frozen       <= 16'h0;
        end else begin
            timer_load   <= do_load;
            session_done <= (state_nx == S_DONE) && (state != S_DONE);
            if (do_load) begin
                timer_value <= load_val;
                baseline    <= volume_ml;
            end
            if (state_nx == S_DONE && state != S_DONE) frozen <= cons;
        end
    end

    // Pause dwell counter: zero outside PAUSE so it restarts on every entry
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                 pause_cnt <= '0;
        else if (state != S_PAUSE)  pause_cnt <= '0;
        else if (tick && pause_cnt < PW'(PAUSE_TO_S)) pause_cnt <= pause_cnt + 1'b1;
    end

    // Message rotation: restart list on any state change, advance every MSG_S ticks
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            msg_sec <= '0;
            msg_idx <= 2'd0;
        end else if (state_nx != state) begin
            msg_sec <= '0;
            msg_idx <= 2'd0;
        end else if (tick) begin
            if (msg_sec >= MW'(MSG_S - 1)) begin
                msg_sec <= '0;
                msg_idx <= (msg_idx >= (((state == S_RUN) || (state == S_DONE)) ? 2'd2 : 2'd1))
                           ? 2'd0 : msg_idx + 1'b1;
            end else begin
                msg_sec <= msg_sec + 1'b1;
            end
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        timer_run  = (state == S_RUN);
        valve_open = (state == S_RUN);
        disp_value = 16'h0;
        msg_id     = 4'd0;
        case (state)
            S_IDLE:    msg_id = (msg_idx == 2'd0) ? 4'd0 : 4'd1;
            S_MENU:    msg_id = (msg_idx == 2'd0) ? 4'd3 : 4'd4;
            S_SET_MIN: begin msg_id = (msg_idx == 2'd0) ? 4'd5 : 4'd14; disp_value = {4'h0, ebuf}; end
            S_SET_DEC: begin msg_id = (msg_idx == 2'd0) ? 4'd6 : 4'd14; disp_value = {4'h0, ebuf}; end
            S_SET_SEG: begin msg_id = (msg_idx == 2'd0) ? 4'd7 : 4'd14; disp_value = {4'h0, ebuf}; end
            S_RUN:     begin
                msg_id = (msg_idx == 2'd0) ? 4'd8 : (msg_idx == 2'd1) ? 4'd9 : 4'd10;
                disp_value = {4'h0, time_left};
            end
            S_PAUSE:   begin msg_id = (msg_idx == 2'd0) ? 4'd1 : 4'd10; disp_value = {4'h0, time_left}; end
            S_DONE:    begin
                msg_id = (msg_idx == 2'd0) ? 4'd11 : (msg_idx == 2'd1) ? 4'd13 : 4'd12;
                disp_value = frozen;
            end
            default:   ;
        endcase
    end
endmodule

// File: tb/tb_shower_session_ctrl.sv
// Directed bench for shower_session_ctrl with a 10-cycle "second".
`timescale 1ns/1ps
module tb_shower_session_ctrl;
    logic        Clk, Rst_n, key_valid, card_valid, occupied, timer_zero;
    logic [3:0]  key_code;
    logic [7:0]  card_id;
    logic [11:0] time_left, timer_value;
    logic [15:0] volume_ml, disp_value;
    logic        timer_load, timer_run, valve_open, session_done;
    logic [3:0]  msg_id;
    logic [2:0]  state;
    int checks = 0, failures = 0;
    int load_cnt = 0, done_cnt = 0;

    shower_session_ctrl #(.CLK_HZ(10)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .key_valid(key_valid), .key_code(key_code),
        .card_valid(card_valid), .card_id(card_id), .occupied(occupied),
        .time_left(time_left), .timer_zero(timer_zero), .volume_ml(volume_ml),
        .timer_load(timer_load), .timer_value(timer_value), .timer_run(timer_run),
        .valve_open(valve_open), .msg_id(msg_id), .disp_value(disp_value),
        .session_done(session_done), .state(state));

    initial begin Clk = 1'b0; forever #5 Clk = ~Clk; end

    // strobe counters, sampled mid-cycle
    always @(negedge Clk) begin
        if (timer_load === 1'b1) load_cnt++;
        if (session_done === 1'b1) done_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic press(input logic [3:0] c);
        key_valid = 1'b1; key_code = c; step(1); key_valid = 1'b0;
    endtask

    task automatic do_reset;
        Rst_n = 1'b0; key_valid = 0; card_valid = 0; occupied = 1; timer_zero = 0;
        volume_ml = 0; time_left = 0; key_code = 0; card_id = 0;
        step(2); Rst_n = 1'b1; step(1);
    endtask

    task automatic test_reset;
        Rst_n = 1'b0; key_valid = 0; card_valid = 0; occupied = 1; timer_zero = 0;
        volume_ml = 0; time_left = 0; key_code = 0; card_id = 0;
        #3;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if ({timer_load, timer_run, valve_open, session_done} !== 4'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {timer_load, timer_run, valve_open, session_done}); end
        checks++; if ({msg_id, disp_value, timer_value} !== 32'h0) begin failures++; $display("FAIL reset_outputs msg=%0d disp=%h tv=%h exp=0", msg_id, disp_value, timer_value); end
        step(2); Rst_n = 1'b1; step(1);
    endtask

    task automatic test_default_run;
        int l0;
        do_reset;
        press(4'hA);
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL menu_entry got=%0d exp=1", state); end
        press(4'hB);
        checks++; if (state !== 3'd5 || timer_load !== 1'b1) begin failures++; $display("FAIL default_run state=%0d load=%b exp=5/1", state, timer_load); end
        checks++; if (timer_value !== 12'h300) begin failures++; $display("FAIL default_value got=%h exp=300", timer_value); end
        checks++; if (valve_open !== 1'b1 || timer_run !== 1'b1) begin failures++; $display("FAIL run_valve got=%b%b exp=11", valve_open, timer_run); end
        l0 = load_cnt;
        step(3);
        checks++; if (load_cnt !== l0 + 1 || timer_load !== 1'b0) begin failures++; $display("FAIL single_load got=%0d exp=%0d", load_cnt - l0, 1); end
    endtask

    task automatic test_program;
        do_reset;
        press(4'hA); press(4'hC);
        checks++; if (state !== 3'd2 || disp_value !== 16'h0) begin failures++; $display("FAIL set_min_entry state=%0d disp=%h exp=2/0000", state, disp_value); end
        press(4'h7);
        checks++; if (disp_value !== 16'h0000) begin failures++; $display("FAIL min_reject got=%h exp=0000", disp_value); end
        press(4'h4); press(4'hF);
        checks++; if (state !== 3'd3 || disp_value !== 16'h0400) begin failures++; $display("FAIL min_accept state=%0d disp=%h exp=3/0400", state, disp_value); end
        press(4'h6);
        checks++; if (disp_value !== 16'h0400) begin failures++; $display("FAIL dec_reject got=%h exp=0400", disp_value); end
        press(4'h3); press(4'hF);
        checks++; if (state !== 3'd4 || disp_value !== 16'h0430) begin failures++; $display("FAIL dec_accept state=%0d disp=%h exp=4/0430", state, disp_value); end
        press(4'h9);
        checks++; if (disp_value !== 16'h0439) begin failures++; $display("FAIL seg_accept got=%h exp=0439", disp_value); end
        press(4'hF);
        checks++; if (state !== 3'd5 || timer_load !== 1'b1 || timer_value !== 12'h439) begin failures++; $display("FAIL prog_load state=%0d load=%b tv=%h exp=5/1/439", state, timer_load, timer_value); end
    endtask

    task automatic test_empty_program;
        do_reset;
        press(4'hA); press(4'hC); press(4'hF); press(4'hF); press(4'hF);
        checks++; if (state !== 3'd5 || timer_value !== 12'h300) begin failures++; $display("FAIL empty_prog state=%0d tv=%h exp=5/300", state, timer_value); end
    endtask

    task automatic test_volume;
        int d0;
        do_reset;
        volume_ml = 16'd1000;
        press(4'hA); press(4'hB);
        volume_ml = 16'd10000; step(1);
        checks++; if (state !== 3'd5) begin failures++; $display("FAIL vol_mid got=%0d exp=5", state); end
        volume_ml = 16'd20999; step(2);
        checks++; if (state !== 3'd5) begin failures++; $display("FAIL vol_below_limit got=%0d exp=5", state); end
        d0 = done_cnt;
        volume_ml = 16'd21000; step(1);
        checks++; if (state !== 3'd7 || session_done !== 1'b1 || valve_open !== 1'b0) begin failures++; $display("FAIL vol_done state=%0d done=%b valve=%b exp=7/1/0", state, session_done, valve_open); end
        checks++; if (disp_value !== 16'd20000) begin failures++; $display("FAIL vol_disp got=%0d exp=20000", disp_value); end
        volume_ml = 16'd30000; step(2);
        checks++; if (disp_value !== 16'd20000 || done_cnt !== d0 + 1) begin failures++; $display("FAIL vol_frozen disp=%0d pulses=%0d exp=20000/1", disp_value, done_cnt - d0); end
    endtask

    task automatic test_pause;
        int l0;
        bit hit;
        do_reset;
        press(4'hA); press(4'hB); step(1);
        time_left = 12'h245;
        l0 = load_cnt;
        occupied = 1'b0; step(1);
        checks++; if (state !== 3'd6 || valve_open !== 1'b0 || timer_run !== 1'b0) begin failures++; $display("FAIL pause_entry state=%0d valve=%b run=%b exp=6/0/0", state, valve_open, timer_run); end
        checks++; if (disp_value !== 16'h0245 || msg_id !== 4'd1) begin failures++; $display("FAIL pause_disp disp=%h msg=%0d exp=0245/1", disp_value, msg_id); end
        occupied = 1'b1; press(4'hA);
        checks++; if (state !== 3'd5 || timer_load !== 1'b0) begin failures++; $display("FAIL resume state=%0d load=%b exp=5/0", state, timer_load); end
        step(2);
        checks++; if (load_cnt !== l0) begin failures++; $display("FAIL resume_noload got=%0d exp=0", load_cnt - l0); end
        press(4'hD);
        checks++; if (state !== 3'd6) begin failures++; $display("FAIL key_d_pause got=%0d exp=6", state); end
        step(580);
        checks++; if (state !== 3'd6) begin failures++; $display("FAIL pause_early got=%0d exp=6", state); end
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (state === 3'd7) hit = 1; else step(1);
        end
        checks++; if (!hit) begin failures++; $display("FAIL pause_timeout state=%0d exp=7", state); end
    endtask

    task automatic test_card;
        int d0;
        do_reset;
        press(4'hA); press(4'hB);
        card_valid = 1'b1; card_id = 8'h11; step(1); card_valid = 1'b0; step(1);
        checks++; if (state !== 3'd5) begin failures++; $display("FAIL bad_card got=%0d exp=5", state); end
        d0 = done_cnt;
        timer_zero = 1'b1; card_valid = 1'b1; card_id = 8'h86; step(1); card_valid = 1'b0;
        checks++; if (state !== 3'd7 || session_done !== 1'b1) begin failures++; $display("FAIL card_done state=%0d done=%b exp=7/1", state, session_done); end
        step(3); timer_zero = 1'b0;
        checks++; if (done_cnt !== d0 + 1) begin failures++; $display("FAIL single_done got=%0d exp=1", done_cnt - d0); end
        press(4'hE);
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL done_exit got=%0d exp=0", state); end
    endtask

    task automatic test_msg;
        bit hit;
        do_reset;
        checks++; if (msg_id !== 4'd0) begin failures++; $display("FAIL msg_idle got=%0d exp=0", msg_id); end
        press(4'hA);
        checks++; if (msg_id !== 4'd3) begin failures++; $display("FAIL msg_menu got=%0d exp=3", msg_id); end
        hit = 0;
        for (int i = 0; i < 25 && !hit; i++) begin
            if (msg_id !== 4'd3) hit = 1; else step(1);
        end
        checks++; if (!hit || msg_id !== 4'd4) begin failures++; $display("FAIL msg_rotate got=%0d exp=4", msg_id); end
        press(4'hB);
        checks++; if (msg_id !== 4'd8) begin failures++; $display("FAIL msg_run got=%0d exp=8", msg_id); end
    endtask

    task automatic test_reset_mid_run;
        do_reset;
        time_left = 12'h159;
        press(4'hA); press(4'hB); step(3);
        #2 Rst_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || valve_open !== 1'b0 || timer_run !== 1'b0) begin failures++; $display("FAIL async_reset state=%0d valve=%b exp=0/0", state, valve_open); end
        checks++; if (disp_value !== 16'h0 || timer_value !== 12'h0) begin failures++; $display("FAIL async_reset_out disp=%h tv=%h exp=0/0", disp_value, timer_value); end
        step(1); Rst_n = 1'b1; step(1);
    endtask

    initial begin
        test_reset;
        test_default_run;
        test_program;
        test_empty_program;
        test_volume;
        test_pause;
        test_card;
        test_msg;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
